// File: rtl/hssi_mac_fiu_if_pkg.sv
// HSSI MAC/FIU lane types plus the shared definitions of the TX lane arbiter.
package hssi_mac_fiu_if_pkg;

  typedef logic [127:0] t_hssi_mf_ln_data;
  typedef logic [17:0]  t_hssi_m2f_ln_ctrl;

  localparam int HSSI_MF_TX_ARB_MAX_REQ = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } t_hssi_mf_tx_arb_state;

  // Requester index width; never narrower than one bit.
  function automatic int hssi_mf_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hssi_mf_tx_arb_if.sv
// Requester-side TX streams and MAC-facing lane of the TX lane arbiter.
// master: requesters + MAC (traffic environment); slave: the arbiter.
interface hssi_mf_tx_arb_if #(
  parameter int N_REQ = 4
);
  import hssi_mac_fiu_if_pkg::*;

  localparam int IDX_W = hssi_mf_idx_w(N_REQ);

  logic [N_REQ-1:0]                    req_valid;
  logic [N_REQ-1:0]                    req_sop;
  logic [N_REQ-1:0]                    req_eop;
  t_hssi_mf_ln_data  [N_REQ-1:0]       req_data;
  t_hssi_m2f_ln_ctrl [N_REQ-1:0]       req_ctrl;
  logic [N_REQ-1:0]                    req_ready;

  logic                                ln_valid;
  logic                                ln_sop;
  logic                                ln_eop;
  t_hssi_mf_ln_data                    ln_data;
  t_hssi_m2f_ln_ctrl                   ln_ctrl;
  logic [IDX_W-1:0]                    ln_grant_idx;
  logic                                ln_ready;

  modport master (
    output req_valid, req_sop, req_eop, req_data, req_ctrl, ln_ready,
    input  req_ready, ln_valid, ln_sop, ln_eop, ln_data, ln_ctrl, ln_grant_idx
  );

  modport slave (
    input  req_valid, req_sop, req_eop, req_data, req_ctrl, ln_ready,
    output req_ready, ln_valid, ln_sop, ln_eop, ln_data, ln_ctrl, ln_grant_idx
  );

endinterface

// File: rtl/hssi_mf_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// scanning upward with wrap at N_REQ.
module hssi_mf_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0] gnt_idx
);

  // Scan N_REQ positions starting at rr_ptr; the first hit wins.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    int unsigned      pos;
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    pos     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = 32'(rr_ptr) + k;
      if (pos >= unsigned'(N_REQ)) pos = pos - unsigned'(N_REQ);
      cand = IDX_W'(pos);
      if (!found && req[cand]) begin
        found         = 1'b1;
        gnt_idx       = cand;
        gnt_oh[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hssi_mf_tx_arb.sv
// Packet-level round-robin arbiter sharing one HSSI MAC-to-FIU TX lane among
// N_REQ requesters. Grant is locked from SOP to EOP; output beat registered.
// Optional feature: define HSSI_MF_TX_ARB_STATS_EN for per-requester
// completed-packet counters (otherwise stat_pkt_cnt is tied to zero).
module hssi_mf_tx_arb
  import hssi_mac_fiu_if_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  hssi_mf_tx_arb_if.slave        bus,
  output logic                   err_orphan,
  output logic [N_REQ-1:0][31:0] stat_pkt_cnt
);

  localparam int IDX_W = hssi_mf_idx_w(N_REQ);

  t_hssi_mf_tx_arb_state state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      lock_idx;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      sel_idx;
  logic [N_REQ-1:0]      sop_cand;
  logic [N_REQ-1:0]      pick_oh;
  logic [N_REQ-1:0]      ready;
  logic                  pick_any;
  logic                  can_load;
  logic                  load;
  logic                  orphan_fire;

  assign can_load = !bus.ln_valid || bus.ln_ready;
  assign sop_cand = bus.req_valid & bus.req_sop;
  assign pick_any = |pick_oh;

  hssi_mf_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (sop_cand),
    .rr_ptr  (rr_ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  // Ready/accept decode; orphan discard picks the lowest valid via x & -x.
  always_comb begin
    ready       = '0;
    load        = 1'b0;
    orphan_fire = 1'b0;
    sel_idx     = lock_idx;
    if (!reset) begin
      if (state == IDLE) begin
        sel_idx = pick_idx;
        if (pick_any) begin
          if (can_load) begin
            ready = pick_oh;
            load  = 1'b1;
          end
        end else if (|bus.req_valid) begin
          ready       = bus.req_valid & (~bus.req_valid + 1'b1);
          orphan_fire = 1'b1;
        end
      end else begin
        ready[lock_idx] = can_load;
        load            = can_load && bus.req_valid[lock_idx];
      end
    end
  end

  assign bus.req_ready = ready;

  // FSM, round-robin pointer, grant lock and registered lane outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      lock_idx         <= '0;
      bus.ln_valid     <= 1'b0;
      bus.ln_sop       <= 1'b0;
      bus.ln_eop       <= 1'b0;
      bus.ln_data      <= '0;
      bus.ln_ctrl      <= '0;
      bus.ln_grant_idx <= '0;
      err_orphan       <= 1'b0;
    end else begin
      err_orphan <= orphan_fire;
      case (state)
        IDLE: begin
          if (load) begin
            rr_ptr   <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            lock_idx <= pick_idx;
            if (!bus.req_eop[pick_idx]) state <= PKT;
          end
        end
        PKT: begin
          if (load && bus.req_eop[lock_idx]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (load) begin
        bus.ln_valid     <= 1'b1;
        bus.ln_sop       <= bus.req_sop[sel_idx];
        bus.ln_eop       <= bus.req_eop[sel_idx];
        bus.ln_data      <= bus.req_data[sel_idx];
        bus.ln_ctrl      <= bus.req_ctrl[sel_idx];
        bus.ln_grant_idx <= sel_idx;
      end else if (bus.ln_ready) begin
        bus.ln_valid <= 1'b0;
      end
    end
  end

`ifdef HSSI_MF_TX_ARB_STATS_EN
  logic [N_REQ-1:0][31:0] stat_cnt_q;

  // Count EOP beats accepted per requester; 32-bit wrap is natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cnt_q <= '0;
    end else if (load && bus.req_eop[sel_idx]) begin
      stat_cnt_q[sel_idx] <= stat_cnt_q[sel_idx] + 32'd1;
    end
  end

  assign stat_pkt_cnt = stat_cnt_q;
`else
  assign stat_pkt_cnt = '0;
`endif

endmodule
